// File: rtl/sequence_player.sv
// Playback sequencer for the LED memory game: walks the pattern ROM from 0 to a
// captured last index, showing each pattern for ON_CYCLES then blanking for OFF_CYCLES.
module sequence_player #(
    parameter int unsigned ON_CYCLES  = 1000,
    parameter int unsigned OFF_CYCLES = 500,
    parameter int unsigned CNT_W      = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       iniciar,
    input  logic [3:0] limite,
    input  logic [3:0] rom_data,
    output logic [3:0] rom_address,
    output logic [3:0] leds,
    output logic       ocupado,
    output logic       pronto,
    output logic [3:0] indice
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_ON    = 3'd3;
    localparam logic [2:0] S_OFF   = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);

    logic [2:0]       state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       lim_r, lim_n;
    logic [3:0]       idx_n;
    logic [3:0]       leds_n;
    logic             ocupado_n;
    logic             pronto_n;

    // State and output registers; rom_address shadows indice
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            cnt         <= '0;
            lim_r       <= '0;
            indice      <= '0;
            rom_address <= '0;
            leds        <= '0;
            ocupado     <= 1'b0;
            pronto      <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            lim_r       <= lim_n;
            indice      <= idx_n;
            rom_address <= idx_n;
            leds        <= leds_n;
            ocupado     <= ocupado_n;
            pronto      <= pronto_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        lim_n     = lim_r;
        idx_n     = indice;
        leds_n    = leds;
        ocupado_n = ocupado;
        pronto_n  = 1'b0;

        case (state)
            S_IDLE: begin
                leds_n    = 4'b0000;
                ocupado_n = 1'b0;
                if (iniciar) begin
                    lim_n     = limite;
                    idx_n     = 4'd0;
                    ocupado_n = 1'b1;
                    state_n   = S_FETCH;
                end
            end
            S_FETCH: begin
                leds_n  = 4'b0000;
                state_n = S_LOAD;
            end
            S_LOAD: begin
                leds_n  = rom_data;
                cnt_n   = '0;
                state_n = S_ON;
            end
            S_ON: begin
                if (cnt == ON_LAST) begin
                    leds_n  = 4'b0000;
                    cnt_n   = '0;
                    state_n = S_OFF;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_OFF: begin
                leds_n = 4'b0000;
                if (cnt == OFF_LAST) begin
                    cnt_n = '0;
                    if (indice == lim_r) begin
                        pronto_n = 1'b1;
                        state_n  = S_DONE;
                    end else begin
                        idx_n   = 4'(indice + 4'd1);
                        state_n = S_FETCH;
                    end
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            S_DONE: begin
                leds_n    = 4'b0000;
                ocupado_n = 1'b0;
                state_n   = S_IDLE;
            end
            default: begin
                leds_n    = 4'b0000;
                ocupado_n = 1'b0;
                state_n   = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sequence_player.sv
// Bench for sequence_player: timeline model of playback checked every cycle,
// plus directed scenarios with hand-computed counts.
module tb_sequence_player;

    localparam int ON  = 4;
    localparam int OFF = 2;
    localparam int P   = 2 + ON + OFF;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       iniciar = 1'b0;
    logic [3:0] limite  = 4'd0;
    logic [3:0] rom_data = 4'd0;
    logic [3:0] rom_address;
    logic [3:0] leds;
    logic       ocupado;
    logic       pronto;
    logic [3:0] indice;

    logic [3:0] rom_mem [16];

    int checks   = 0;
    int failures = 0;

    sequence_player #(
        .ON_CYCLES (ON),
        .OFF_CYCLES(OFF),
        .CNT_W     (16)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .iniciar    (iniciar),
        .limite     (limite),
        .rom_data   (rom_data),
        .rom_address(rom_address),
        .leds       (leds),
        .ocupado    (ocupado),
        .pronto     (pronto),
        .indice     (indice)
    );

    always #5 clock = ~clock;

    // Pattern ROM with one cycle of read latency
    always @(posedge clock) rom_data <= rom_mem[rom_address];

    // Timeline model: a playback is just a start cycle plus the captured limit
    bit         m_started = 1'b0;
    int         m_cyc     = 0;
    int         m_t0      = 0;
    logic [3:0] m_lim     = 4'd0;

    function automatic bit m_idle();
        return !m_started || ((m_cyc - m_t0) > (int'(m_lim) + 1) * P);
    endfunction

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            m_started <= 1'b0;
            m_cyc     <= 0;
            m_t0      <= 0;
            m_lim     <= 4'd0;
        end else begin
            m_cyc <= m_cyc + 1;
            if (m_idle() && iniciar) begin
                m_started <= 1'b1;
                m_t0      <= m_cyc + 1;
                m_lim     <= limite;
            end
        end
    end

    task automatic model_exp(output logic [3:0] e_leds, output logic [3:0] e_idx,
                             output logic e_ocu, output logic e_pr);
        int k;
        int last;
        e_leds = 4'd0;
        e_idx  = 4'd0;
        e_ocu  = 1'b0;
        e_pr   = 1'b0;
        if (m_started) begin
            k     = m_cyc - m_t0;
            last  = (int'(m_lim) + 1) * P;
            e_idx = m_lim;
            if (k < last) begin
                e_idx = 4'(k / P);
                e_ocu = 1'b1;
                if ((k % P) >= 2 && (k % P) < 2 + ON) e_leds = rom_mem[e_idx];
            end else if (k == last) begin
                e_ocu = 1'b1;
                e_pr  = 1'b1;
            end
        end
    endtask

    // Advance to the next falling edge and compare every output against the model
    task automatic tick();
        logic [3:0] e_leds;
        logic [3:0] e_idx;
        logic       e_ocu;
        logic       e_pr;
        @(negedge clock);
        model_exp(e_leds, e_idx, e_ocu, e_pr);
        checks++;
        if ({leds, rom_address, indice, ocupado, pronto} !== {e_leds, e_idx, e_idx, e_ocu, e_pr}) begin
            failures++;
            $display("FAIL cycle t=%0t leds=%b/%b addr=%0d/%0d indice=%0d/%0d ocupado=%b/%b pronto=%b/%b (actual/required)",
                     $time, leds, e_leds, rom_address, e_idx, indice, e_idx, ocupado, e_ocu, pronto, e_pr);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    int r_ocu, r_pr, r_pr_pos, r_first_on, r_n1, r_n2, r_n4, r_dark, r_max_addr, r_order_ok, r_to;

    // Start one playback from a falling edge and gather statistics until ocupado drops
    task automatic play(input logic [3:0] lim, input bit hold, input bit disturb, input int budget);
        int         n;
        bit         seen;
        bit         dist_done;
        bit         ended;
        logic [3:0] last_addr;
        r_ocu = 0; r_pr = 0; r_pr_pos = -1; r_first_on = 0;
        r_n1 = 0; r_n2 = 0; r_n4 = 0; r_dark = 0; r_max_addr = 0; r_order_ok = 1;
        seen = 1'b0; dist_done = 1'b0; ended = 1'b0; n = 0; last_addr = 4'd0;
        limite  = lim;
        iniciar = 1'b1;
        while (n < budget && !ended) begin
            tick();
            n++;
            iniciar = hold;
            if (ocupado) begin
                if (!seen) begin
                    seen      = 1'b1;
                    last_addr = rom_address;
                end
                r_ocu++;
                if (pronto) begin
                    r_pr++;
                    r_pr_pos = r_ocu - 1;
                end
                if (leds == 4'b0000) r_dark++;
                if (leds == 4'b0001) r_n1++;
                if (leds == 4'b0010) r_n2++;
                if (leds == 4'b0100) r_n4++;
                if (r_first_on == 0 && leds != 4'b0000) r_first_on = n;
                if (rom_address != last_addr) begin
                    if (rom_address != 4'(last_addr + 4'd1)) r_order_ok = 0;
                    last_addr = rom_address;
                end
                if (int'(rom_address) > r_max_addr) r_max_addr = int'(rom_address);
                if (disturb && !dist_done && leds == 4'b0010) begin
                    iniciar   = 1'b1;
                    limite    = 4'd15;
                    dist_done = 1'b1;
                end
            end else if (seen) begin
                ended = 1'b1;
            end
        end
        r_to = ended ? 0 : 1;
    endtask

    initial begin
        int  act;
        bit  found;

        for (int i = 0; i < 16; i++) rom_mem[i] = 4'(15 - i);
        rom_mem[0] = 4'b0001;
        rom_mem[1] = 4'b0010;
        rom_mem[2] = 4'b0100;

        // Reset values and quiet idle
        repeat (3) tick();
        chk("reset_leds", int'(leds), 0);
        chk("reset_addr", int'(rom_address), 0);
        chk("reset_ocupado", int'(ocupado), 0);
        chk("reset_pronto", int'(pronto), 0);
        chk("reset_indice", int'(indice), 0);
        reset_n = 1'b1;
        act = 0;
        repeat (20) begin
            tick();
            if (ocupado || pronto || leds != 4'b0000) act = 1;
        end
        chk("idle_activity", act, 0);

        // Basic three-pattern playback
        play(4'd2, 1'b0, 1'b0, 100);
        chk("basic_timeout", r_to, 0);
        chk("basic_ocupado_cycles", r_ocu, 25);
        chk("basic_pronto_cycles", r_pr, 1);
        chk("basic_pronto_pos", r_pr_pos, 24);
        chk("basic_first_on", r_first_on, 3);
        chk("basic_leds_0001", r_n1, 4);
        chk("basic_leds_0010", r_n2, 4);
        chk("basic_leds_0100", r_n4, 4);
        chk("basic_dark", r_dark, 13);
        chk("basic_max_addr", r_max_addr, 2);

        // Single pattern
        play(4'd0, 1'b0, 1'b0, 50);
        chk("single_timeout", r_to, 0);
        chk("single_ocupado_cycles", r_ocu, 9);
        chk("single_pronto_pos", r_pr_pos, 8);
        chk("single_leds_0001", r_n1, 4);
        chk("single_max_addr", r_max_addr, 0);

        // Start pulse and limit change mid-playback are ignored
        play(4'd2, 1'b0, 1'b1, 100);
        chk("ignore_timeout", r_to, 0);
        chk("ignore_ocupado_cycles", r_ocu, 25);
        chk("ignore_pronto_cycles", r_pr, 1);
        chk("ignore_max_addr", r_max_addr, 2);

        // Full range with start held high
        play(4'd15, 1'b1, 1'b0, 300);
        chk("full_timeout", r_to, 0);
        chk("full_ocupado_cycles", r_ocu, 129);
        chk("full_pronto_pos", r_pr_pos, 128);
        chk("full_pronto_cycles", r_pr, 1);
        chk("full_max_addr", r_max_addr, 15);
        chk("full_addr_order", r_order_ok, 1);
        tick();
        chk("restart_ocupado", int'(ocupado), 1);
        chk("restart_indice", int'(indice), 0);
        iniciar = 1'b0;

        // Asynchronous reset while pattern 1 is lit
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick();
            if (leds == 4'b0010) found = 1'b1;
        end
        chk("wait_leds_0010", int'(found), 1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_leds", int'(leds), 0);
        chk("async_ocupado", int'(ocupado), 0);
        chk("async_indice", int'(indice), 0);
        chk("async_addr", int'(rom_address), 0);
        tick();
        tick();
        reset_n = 1'b1;
        act = 0;
        repeat (10) begin
            tick();
            if (ocupado || pronto || leds != 4'b0000) act = 1;
        end
        chk("post_reset_idle", act, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
